apa102_frame_ctrl: RTL and testbench

Frame controller for the APA102 SPI receive path. It shadows the receiver's bit framing on the same `sck`/`sda` inputs and detects each complete 7-LED frame. It snapshots the receiver's 168-bit `data_out` into a shadow buffer and serves the LEDs one at a time to a downstream renderer over a valid/ready handshake. It also owns the receiver's reset, pulsing it to resynchronise after a stalled or truncated transfer.

---
 rtl/apa102_pkg.sv | 25 ++
 rtl/apa102_bit_tracker.sv | 101 ++++++++++
 rtl/apa102_frame_ctrl.sv | 141 ++++++++++++++
 tb/tb_apa102_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apa102_pkg.sv
// Shared constants, state encodings and helpers for the APA102 frame controller.
package apa102_pkg;

    localparam int START_BITS = 32;
    localparam int LED_BITS   = 32;
    localparam int PIXEL_W    = 24;
    localparam int TAIL_BITS  = 32;

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        TAIL
    } trk_state_t;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } serve_state_t;

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/apa102_bit_tracker.sv
// Shadows the receiver's bit framing: start run, LED data, end frame.
// Emits a one-cycle frame_done on the last data edge and a one-cycle abort
// when sck stalls inside a frame.
module apa102_bit_tracker
    import apa102_pkg::*;
#(
    parameter int NUM_LEDS       = 7,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic sda,
    output logic frame_done,
    output logic abort
);

    localparam int DATA_BITS = NUM_LEDS * LED_BITS;
    localparam int BIT_W     = $clog2((DATA_BITS > TAIL_BITS) ? DATA_BITS : TAIL_BITS);
    localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

    logic             last_sck;
    logic             sck_rise;
    trk_state_t       state, state_n;
    logic [7:0]       zero_cnt, zero_n;
    logic [BIT_W-1:0] bit_cnt, bit_n;
    logic [TO_W-1:0]  to_cnt, to_n;

    // sck is deliberately not synchronised so edges line up with the receiver.
    assign sck_rise = sck & ~last_sck;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_sck <= 1'b0;
            state    <= HUNT;
            zero_cnt <= '0;
            bit_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            last_sck <= sck;
            state    <= state_n;
            zero_cnt <= zero_n;
            bit_cnt  <= bit_n;
            to_cnt   <= to_n;
        end
    end

    // Next-state: framing advances on sck edges, the stall timer on clk.
    always_comb begin
        state_n    = state;
        zero_n     = zero_cnt;
        bit_n      = bit_cnt;
        to_n       = to_cnt;
        frame_done = 1'b0;
        abort      = 1'b0;

        if (sck_rise)
            to_n = '0;
        else if (state != HUNT)
            to_n = to_cnt + 1'b1;

        if (state != HUNT && !sck_rise && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            abort   = 1'b1;
            state_n = HUNT;
            zero_n  = '0;
            bit_n   = '0;
            to_n    = '0;
        end else if (sck_rise) begin
            case (state)
                HUNT: begin
                    if (sda)
                        zero_n = '0;
                    else if (zero_cnt == 8'(START_BITS - 1)) begin
                        state_n = DATA;
                        zero_n  = '0;
                        bit_n   = '0;
                    end else
                        zero_n = zero_cnt + 8'd1;
                end
                DATA: begin
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        frame_done = 1'b1;
                        state_n    = TAIL;
                        bit_n      = '0;
                    end else
                        bit_n = bit_cnt + 1'b1;
                end
                TAIL: begin
                    if (bit_cnt == BIT_W'(TAIL_BITS - 1)) begin
                        state_n = HUNT;
                        bit_n   = '0;
                    end else
                        bit_n = bit_cnt + 1'b1;
                end
                default: state_n = HUNT;
            endcase
        end
    end

endmodule

// File: rtl/apa102_frame_ctrl.sv
// APA102 frame controller: snapshots each complete receiver frame into a
// shadow buffer and serves it pixel by pixel over valid/ready. Also pulses
// the receiver reset after a stalled transfer.
module apa102_frame_ctrl
    import apa102_pkg::*;
#(
    parameter int NUM_LEDS       = 7,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sck,
    input  logic                          sda,
    input  logic [PIXEL_W*NUM_LEDS-1:0]   rx_data,
    output logic                          rx_rst_n,
    output logic                          led_valid,
    input  logic                          led_ready,
    output logic [2:0]                    led_index,
    output logic [PIXEL_W-1:0]            led_rgb,
    output logic [7:0]                    frame_count,
    output logic [7:0]                    drop_count,
    output logic [7:0]                    timeout_count
);

    localparam int         FRAME_W  = PIXEL_W * NUM_LEDS;
    localparam logic [2:0] LAST_IDX = 3'(NUM_LEDS - 1);

    logic               frame_done;
    logic               abort;
    logic [1:0]         snap_pipe;
    logic               snap;
    logic               rst_hold;
    serve_state_t       serve, serve_n;
    logic [2:0]         idx_n;
    logic               accept;
    logic               drop;
    logic [FRAME_W-1:0] shadow;
    logic [PIXEL_W-1:0] pix;

    apa102_bit_tracker #(
        .NUM_LEDS       (NUM_LEDS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .sck        (sck),
        .sda        (sda),
        .frame_done (frame_done),
        .abort      (abort)
    );

    // Delay frame_done two cycles so the receiver's final write has landed.
    always_ff @(posedge clk) begin
        if (rst)
            snap_pipe <= '0;
        else
            snap_pipe <= {snap_pipe[0], frame_done};
    end

    assign snap = snap_pipe[1];

    // Receiver reset: low in rst, and low for two cycles after an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_rst_n <= 1'b0;
            rst_hold <= 1'b0;
        end else if (abort) begin
            rx_rst_n <= 1'b0;
            rst_hold <= 1'b1;
        end else if (rst_hold) begin
            rx_rst_n <= 1'b0;
            rst_hold <= 1'b0;
        end else begin
            rx_rst_n <= 1'b1;
        end
    end

    // Serve FSM registers, shadow buffer and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            serve         <= S_IDLE;
            led_index     <= '0;
            shadow        <= '0;
            frame_count   <= '0;
            drop_count    <= '0;
            timeout_count <= '0;
        end else begin
            serve     <= serve_n;
            led_index <= idx_n;
            if (accept) begin
                shadow      <= rx_data;
                frame_count <= frame_count + 8'd1;
            end
            if (drop)
                drop_count <= sat_inc8(drop_count);
            if (abort)
                timeout_count <= sat_inc8(timeout_count);
        end
    end

    // Serve next-state: a snap while sending (even on the last beat) is a drop.
    always_comb begin
        serve_n = serve;
        idx_n   = led_index;
        accept  = 1'b0;
        drop    = 1'b0;
        case (serve)
            S_IDLE: begin
                if (snap) begin
                    serve_n = S_SEND;
                    idx_n   = '0;
                    accept  = 1'b1;
                end
            end
            S_SEND: begin
                if (snap)
                    drop = 1'b1;
                if (led_ready) begin
                    if (led_index == LAST_IDX) begin
                        serve_n = S_IDLE;
                        idx_n   = '0;
                    end else
                        idx_n = led_index + 3'd1;
                end
            end
            default: serve_n = S_IDLE;
        endcase
    end

    // Pixel mux: LED 0 sits in the most significant word of the frame.
    always_comb begin
        pix = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            if (led_index == 3'(i))
                pix = shadow[FRAME_W-1-PIXEL_W*i -: PIXEL_W];
    end

    assign led_valid = (serve == S_SEND);
    assign led_rgb   = led_valid ? pix : '0;

endmodule

// File: tb/tb_apa102_frame_ctrl.sv
// Randomised self-checking bench for apa102_frame_ctrl against a frame-level model.
module tb_apa102_frame_ctrl;

    localparam int NL = 7;
    localparam int FW = 24 * NL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sck = 1'b0;
    logic          sda = 1'b0;
    logic [FW-1:0] rx_data = '0;
    logic          led_ready = 1'b0;
    logic          rx_rst_n;
    logic          led_valid;
    logic [2:0]    led_index;
    logic [23:0]   led_rgb;
    logic [7:0]    frame_count, drop_count, timeout_count;

    apa102_frame_ctrl #(.NUM_LEDS(NL), .TIMEOUT_CYCLES(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .sck           (sck),
        .sda           (sda),
        .rx_data       (rx_data),
        .rx_rst_n      (rx_rst_n),
        .led_valid     (led_valid),
        .led_ready     (led_ready),
        .led_index     (led_index),
        .led_rgb       (led_rgb),
        .frame_count   (frame_count),
        .drop_count    (drop_count),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: pixels still owed downstream plus expected statistics.
    logic [26:0] exp_q[$];
    int          exp_frames = 0;
    int          exp_drops  = 0;
    int          exp_touts  = 0;
    logic [23:0] pix [NL];

    // led_ready pattern: 0 always, 1 one-in-four, 2 held low, 3 random.
    int ready_mode = 2;
    int rcyc = 0;
    initial forever begin
        @(posedge clk); #1;
        rcyc++;
        case (ready_mode)
            0:       led_ready = 1'b1;
            1:       led_ready = (rcyc % 4 == 0);
            2:       led_ready = 1'b0;
            default: led_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Transfer monitor: in-order pixel check and hold-stability check.
    logic        prev_hold = 1'b0;
    logic [2:0]  prev_idx;
    logic [23:0] prev_rgb;
    logic [26:0] mon_e;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(led_valid), 32'd1);
                chk("hold_idx", 32'(led_index), 32'(prev_idx));
                chk("hold_rgb", 32'(led_rgb), 32'(prev_rgb));
            end
            if (led_valid && led_ready) begin
                if (exp_q.size() == 0)
                    chk("spurious_xfer", 32'(led_valid & led_ready), 32'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("xfer_idx", 32'(led_index), 32'(mon_e[26:24]));
                    chk("xfer_rgb", 32'(led_rgb), 32'(mon_e[23:0]));
                end
            end
            prev_hold = led_valid && !led_ready;
            prev_idx  = led_index;
            prev_rgb  = led_rgb;
        end
    end

    task automatic send_bit(input logic b);
        sda = b;
        sck = 1'b0;
        @(posedge clk); #1;
        sck = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_word32(input logic [31:0] w);
        for (int i = 31; i >= 0; i--)
            send_bit(w[i]);
    endtask

    // Full frame from pix[]; a bad preamble carries a 1 at bit 20.
    task automatic send_frame(input bit good_pre);
        for (int n = 0; n < NL; n++)
            rx_data[FW-1-24*n -: 24] = pix[n];
        for (int i = 0; i < 32; i++)
            send_bit(good_pre ? 1'b0 : (i == 20));
        for (int n = 0; n < NL; n++)
            send_word32({8'hFF, pix[n]});
        if (good_pre) begin
            if (exp_q.size() == 0) begin
                for (int n = 0; n < NL; n++)
                    exp_q.push_back({3'(n), pix[n]});
                exp_frames++;
            end else if (exp_drops < 255)
                exp_drops++;
        end
        for (int i = 0; i < 32; i++)
            send_bit(1'b1);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 400 && (exp_q.size() != 0 || led_valid); c++)
            @(negedge clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
        chk("idle_valid", 32'(led_valid), 32'd0);
    endtask

    task automatic chk_counts();
        chk("frame_count", 32'(frame_count), 32'(exp_frames[7:0]));
        chk("drop_count", 32'(drop_count), 32'(exp_drops));
        chk("timeout_count", 32'(timeout_count), 32'(exp_touts));
    endtask

    task automatic rand_pix();
        for (int n = 0; n < NL; n++)
            pix[n] = 24'($urandom());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int low;
        int c;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_rst_n", 32'(rx_rst_n), 32'd0);
        chk("rst_valid", 32'(led_valid), 32'd0);
        chk("rst_index", 32'(led_index), 32'd0);
        chk("rst_rgb", 32'(led_rgb), 32'd0);
        chk_counts();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rx_rst_n_release", 32'(rx_rst_n), 32'd1);

        // Known pattern, ready held high.
        for (int n = 0; n < NL; n++)
            pix[n] = 24'(32'h111111 * (n + 1));
        ready_mode = 0;
        send_frame(1'b1);
        drain("drain_ready_high");
        chk_counts();

        // Same frame, ready one cycle on, three off.
        ready_mode = 1;
        send_frame(1'b1);
        drain("drain_ready_pulsed");
        chk_counts();

        // Back-to-back frames with ready low: second must be dropped.
        ready_mode = 2;
        rand_pix();
        send_frame(1'b1);
        rand_pix();
        send_frame(1'b1);
        ready_mode = 0;
        drain("drain_after_drop");
        chk_counts();

        // Broken preamble stays in HUNT, then a clean frame is taken.
        rand_pix();
        send_frame(1'b0);
        repeat (10) @(negedge clk);
        chk_counts();
        rand_pix();
        send_frame(1'b1);
        drain("drain_after_bad_pre");
        chk_counts();

        // sck stalls after 100 data bits.
        rand_pix();
        for (int i = 0; i < 32; i++)
            send_bit(1'b0);
        for (int i = 0; i < 100; i++)
            send_bit(1'($urandom_range(0, 1)));
        sck = 1'b0;
        c = 0;
        while (rx_rst_n && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("timeout_seen", 32'(rx_rst_n), 32'd0);
        low = 0;
        while (!rx_rst_n && low < 10) begin
            low++;
            @(negedge clk);
        end
        chk("rx_rst_low_len", 32'(low), 32'd2);
        exp_touts++;
        chk_counts();
        chk("timeout_no_valid", 32'(led_valid), 32'd0);
        rand_pix();
        send_frame(1'b1);
        drain("drain_after_timeout");
        chk_counts();

        // Random frames with random backpressure.
        ready_mode = 3;
        for (int f = 0; f < 4; f++) begin
            rand_pix();
            send_frame(1'b1);
            drain("drain_random");
            chk_counts();
        end

        // Reset while LED 3 is being offered.
        ready_mode = 2;
        rand_pix();
        send_frame(1'b1);
        ready_mode = 1;
        c = 0;
        while (!(led_valid && led_index == 3'd3) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("reach_led3", 32'(led_index), 32'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        exp_frames = 0;
        exp_drops  = 0;
        exp_touts  = 0;
        chk("midrst_valid", 32'(led_valid), 32'd0);
        chk("midrst_index", 32'(led_index), 32'd0);
        chk("midrst_rx_rst_n", 32'(rx_rst_n), 32'd0);
        chk_counts();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_release", 32'(rx_rst_n), 32'd1);

        // Recovery after reset.
        ready_mode = 0;
        rand_pix();
        send_frame(1'b1);
        drain("drain_after_rst");
        chk_counts();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
